// File: rtl/alu_pkg.sv
// alu_pkg: shared state encodings, default datapath width and flag-bundle layout for the ALU result path.
package alu_pkg;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic ovf;
        logic neg;
        logic zero;
    } flags_t;
endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational zero/negative flags of a result word.
module alu_flag_gen #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             neg
);
    assign zero = (z == '0);
    assign neg  = z[WIDTH-1];
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry in-order registered buffer for sub32 results with precomputed flags.
// Optional sticky overflow flag and saturating counter with macro ALU_RESULT_STAGE_STICKY_OVF_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
    ,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_count
`endif
);
    state_t           state;
    logic [WIDTH-1:0] head_z, tail_z;
    flags_t           head_f, tail_f, in_f;
    logic             in_zero, in_neg, push, pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
        .z    (in_z),
        .zero (in_zero),
        .neg  (in_neg)
    );

    assign in_f      = '{ovf: in_overflow, neg: in_neg, zero: in_zero};
    assign in_ready  = (state != FULL);
    assign out_valid = (state == ONE) || (state == FULL);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_z    = head_z;
    assign out_zero = head_f.zero;
    assign out_neg  = head_f.neg;
    assign out_ovf  = head_f.ovf;

    // Head register drives the outputs directly; the tail only fills while the head is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            head_z <= '0;
            head_f <= '0;
            tail_z <= '0;
            tail_f <= '0;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    head_z <= in_z;
                    head_f <= in_f;
                    state  <= ONE;
                end
                ONE: if (push && pop) begin
                    head_z <= in_z;
                    head_f <= in_f;
                end else if (push) begin
                    tail_z <= in_z;
                    tail_f <= in_f;
                    state  <= FULL;
                end else if (pop) begin
                    state <= EMPTY;
                end
                FULL: if (pop) begin
                    head_z <= tail_z;
                    head_f <= tail_f;
                    state  <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
    logic ovf_push;
    assign ovf_push = push && in_overflow;

    // A clear coinciding with an overflow push restarts the count at that push.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (clr_sticky) begin
            sticky_ovf <= ovf_push;
            ovf_count  <= CNT_W'(ovf_push);
        end else if (ovf_push) begin
            sticky_ovf <= 1'b1;
            if (ovf_count != '1)
                ovf_count <= ovf_count + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: table vectors plus hand sequences, checked against a queue scoreboard.
module tb_alu_result_stage;
    typedef struct {
        logic [31:0] z;
        logic        ovf;
        logic        zero;
        logic        neg;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_z = '0;
    logic        in_overflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic        out_zero, out_neg, out_ovf;
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
    logic        clr_sticky = 1'b0;
    logic        sticky_ovf;
    logic [1:0]  ovf_count;
`endif

    int   tests = 0;
    int   fails = 0;
    ent_t q[$];
    ent_t last;
    ent_t tbl[5];
    logic m_sticky;
    int   m_cnt;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(32), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_z        (in_z),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_z       (out_z),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_ovf     (out_ovf)
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
        ,
        .clr_sticky  (clr_sticky),
        .sticky_ovf  (sticky_ovf),
        .ovf_count   (ovf_count)
`endif
    );

    function automatic ent_t mk(input logic [31:0] z, input logic o);
        ent_t e;
        e.z    = z;
        e.ovf  = o;
        e.zero = (z == 32'd0);
        e.neg  = z[31];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the scoreboard, then check every output.
    task automatic step(input logic v, input ent_t e, input logic rdy, input logic r, input logic clr);
        logic p_push, p_pop;
        in_valid    = v;
        in_z        = e.z;
        in_overflow = e.ovf;
        out_ready   = rdy;
        rst         = r;
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
        clr_sticky  = clr;
`endif
        if (r) begin
            q.delete();
            last     = '{default: '0};
            m_sticky = 1'b0;
            m_cnt    = 0;
        end else begin
            p_push = v && (q.size() < 2);
            p_pop  = rdy && (q.size() > 0);
            if (p_pop) q.delete(0);
            if (p_push) q.push_back(e);
            if (clr) begin
                m_sticky = p_push && e.ovf;
                m_cnt    = (p_push && e.ovf) ? 1 : 0;
            end else if (p_push && e.ovf) begin
                m_sticky = 1'b1;
                if (m_cnt < 3) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        if (q.size() > 0) last = q[0];
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
        chk("out_z",     out_z,          last.z);
        chk("out_zero",  32'(out_zero),  32'(last.zero));
        chk("out_neg",   32'(out_neg),   32'(last.neg));
        chk("out_ovf",   32'(out_ovf),   32'(last.ovf));
`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
        chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
        chk("ovf_count",  32'(ovf_count),  32'(m_cnt));
`endif
    endtask

    initial begin
        ent_t idle;
        idle = mk(32'd0, 1'b0);
        tbl[0] = '{z: 32'h8000_0000, ovf: 1'b0, zero: 1'b0, neg: 1'b1};
        tbl[1] = '{z: 32'h7FFF_FFFF, ovf: 1'b1, zero: 1'b0, neg: 1'b0};
        tbl[2] = '{z: 32'h0000_0000, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
        tbl[3] = '{z: 32'h0000_0001, ovf: 1'b0, zero: 1'b0, neg: 1'b0};
        tbl[4] = '{z: 32'hFFFF_FFFF, ovf: 1'b1, zero: 1'b0, neg: 1'b1};

        step(1'b0, idle, 1'b0, 1'b1, 1'b0);
        step(1'b0, idle, 1'b0, 1'b1, 1'b0);

        // Streaming with out_ready=1: each push becomes the head on the next cycle.
        for (int i = 0; i < 5; i++) step(1'b1, tbl[i], 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Back-pressure: third push while full must be dropped.
        step(1'b1, mk(32'h1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h2, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h3, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b0, idle, 1'b0, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Simultaneous push and pop in ONE.
        step(1'b1, mk(32'h5, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h0, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b0, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Reset while FULL, with a push and pop requested in the reset cycle.
        step(1'b1, mk(32'hA, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'hB, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'hC, 1'b1), 1'b1, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Overflow saturation, then clear colliding with an overflow push, then plain clear.
        for (int i = 0; i < 5; i++) step(1'b1, mk(32'h7FFF_FFFF, 1'b1), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(32'h7FFF_FFF0, 1'b1), 1'b1, 1'b0, 1'b1);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
